// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost targeting block.
package ghost_pkg;

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_FRIGHT  = 2'd2,
    MODE_EATEN   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam int PERS_BLINKY = 0;
  localparam int PERS_PINKY  = 1;
  localparam int PERS_INKY   = 2;
  localparam int PERS_CLYDE  = 3;

  // Ghost-house tile {row 2^(ROW_W-1), col 2^(COL_W-1)}; caller truncates to POS_W.
  function automatic logic [31:0] home_tile(input int row_w, input int col_w);
    return (32'd1 << (row_w - 1 + col_w)) | (32'd1 << (col_w - 1));
  endfunction

endpackage

// File: rtl/ghost_target_calc.sv
// Combinational target-tile selection per mode and personality, with per-axis
// signed arithmetic clamped to the maze.
module ghost_target_calc import ghost_pkg::*; #(
  parameter int PERSONALITY = PERS_CLYDE,
  parameter int COL_W       = 5,
  parameter int ROW_W       = 5,
  parameter int SHY_RADIUS  = 5,
  parameter logic [ROW_W+COL_W-1:0] SCATTER_CORNER = '0
) (
  input  mode_t                    mode,
  input  logic [ROW_W+COL_W-1:0]   pac_pos,
  input  logic [1:0]               pac_dir,
  input  logic [ROW_W+COL_W-1:0]   blinky_pos,
  input  logic [ROW_W+COL_W-1:0]   ghost_pos,
  input  logic [ROW_W+COL_W-1:0]   fright_tgt,
  output logic [ROW_W+COL_W-1:0]   tgt
);
  localparam int POS_W = ROW_W + COL_W;
  localparam int RW2   = ROW_W + 2;
  localparam int CW2   = COL_W + 2;
  localparam logic [POS_W-1:0] HOME = POS_W'(home_tile(ROW_W, COL_W));

  function automatic logic [ROW_W-1:0] clamp_r(input logic signed [RW2-1:0] v);
    if (v[RW2-1]) return '0;
    if (v[ROW_W]) return '1;
    return v[ROW_W-1:0];
  endfunction

  function automatic logic [COL_W-1:0] clamp_c(input logic signed [CW2-1:0] v);
    if (v[CW2-1]) return '0;
    if (v[COL_W]) return '1;
    return v[COL_W-1:0];
  endfunction

  logic [ROW_W-1:0] pac_r, bl_r, gh_r, look2_r;
  logic [COL_W-1:0] pac_c, bl_c, gh_c, look2_c;
  logic signed [RW2-1:0] pr, step_r, pinky_r, inky_r, dr, adr;
  logic signed [CW2-1:0] pc, step_c, pinky_c, inky_c, dc, adc;
  logic near;

  assign {pac_r, pac_c} = pac_pos;
  assign {bl_r, bl_c}   = blinky_pos;
  assign {gh_r, gh_c}   = ghost_pos;
  assign pr = $signed({2'b00, pac_r});
  assign pc = $signed({2'b00, pac_c});

  always_comb begin
    step_r = '0;
    step_c = '0;
    unique case (dir_t'(pac_dir))
      DIR_UP:    step_r = '1;
      DIR_DOWN:  step_r = RW2'(1);
      DIR_RIGHT: step_c = CW2'(1);
      DIR_LEFT:  step_c = '1;
    endcase
  end

  // Clamping the 2-tile lookahead before doubling keeps inky inside width+2
  // without changing the clamped result.
  assign pinky_r = pr + (step_r <<< 2);
  assign pinky_c = pc + (step_c <<< 2);
  assign look2_r = clamp_r(pr + (step_r <<< 1));
  assign look2_c = clamp_c(pc + (step_c <<< 1));
  assign inky_r  = ($signed({2'b00, look2_r}) <<< 1) - $signed({2'b00, bl_r});
  assign inky_c  = ($signed({2'b00, look2_c}) <<< 1) - $signed({2'b00, bl_c});

  assign dr   = $signed({2'b00, gh_r}) - pr;
  assign dc   = $signed({2'b00, gh_c}) - pc;
  assign adr  = dr[RW2-1] ? -dr : dr;
  assign adc  = dc[CW2-1] ? -dc : dc;
  assign near = (int'(adr) < SHY_RADIUS) && (int'(adc) < SHY_RADIUS);

  always_comb begin
    tgt = SCATTER_CORNER;
    unique case (mode)
      MODE_SCATTER: tgt = SCATTER_CORNER;
      MODE_EATEN:   tgt = HOME;
      MODE_FRIGHT:  tgt = fright_tgt;
      MODE_CHASE: begin
        if (PERSONALITY == PERS_BLINKY)     tgt = pac_pos;
        else if (PERSONALITY == PERS_PINKY) tgt = {clamp_r(pinky_r), clamp_c(pinky_c)};
        else if (PERSONALITY == PERS_INKY)  tgt = {clamp_r(inky_r), clamp_c(inky_c)};
        else                                tgt = near ? SCATTER_CORNER : pac_pos;
      end
    endcase
  end

endmodule

// File: rtl/ghost_target_fsm.sv
// Ghost mode sequencer (scatter/chase schedule, fright, eaten) with a
// registered target handshake. Optional GHOST_LFSR_EN randomizes fright targets.
module ghost_target_fsm import ghost_pkg::*; #(
  parameter int PERSONALITY   = PERS_CLYDE,
  parameter int COL_W         = 5,
  parameter int ROW_W         = 5,
  parameter int SHY_RADIUS    = 5,
  parameter int SCATTER_TICKS = 7,
  parameter int CHASE_TICKS   = 20,
  parameter int FRIGHT_TICKS  = 6,
  parameter int NUM_PHASES    = 4,
  parameter logic [ROW_W+COL_W-1:0] SCATTER_CORNER = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [ROW_W+COL_W-1:0]   pac_pos,
  input  logic [1:0]               pac_dir,
  input  logic [ROW_W+COL_W-1:0]   blinky_pos,
  input  logic [ROW_W+COL_W-1:0]   ghost_pos,
  input  logic                     power_pellet,
  input  logic                     eaten,
  input  logic                     at_home,
  input  logic                     target_ready,
  output logic                     target_valid,
  output logic [ROW_W+COL_W-1:0]   target_pos,
  output logic [1:0]               mode
);
  localparam int POS_W = ROW_W + COL_W;
  localparam int TMAX  = (SCATTER_TICKS > CHASE_TICKS)
                         ? ((SCATTER_TICKS > FRIGHT_TICKS) ? SCATTER_TICKS : FRIGHT_TICKS)
                         : ((CHASE_TICKS > FRIGHT_TICKS) ? CHASE_TICKS : FRIGHT_TICKS);
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam int PH_W  = $clog2(2 * NUM_PHASES);
  localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(2 * NUM_PHASES - 1);
  localparam logic [TMR_W-1:0] T_SCATTER = TMR_W'(SCATTER_TICKS);
  localparam logic [TMR_W-1:0] T_CHASE   = TMR_W'(CHASE_TICKS);
  localparam logic [TMR_W-1:0] T_FRIGHT  = TMR_W'(FRIGHT_TICKS);

  mode_t             mode_q, mode_d, saved_q, saved_d;
  logic [TMR_W-1:0]  sched_q, sched_d, fright_q, fright_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [POS_W-1:0]  tgt_q, tgt_d, calc_tgt, fright_tgt;
  logic              vld_q, vld_d;

`ifdef GHOST_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d     = tick ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                           : lfsr_q;
  assign fright_tgt = lfsr_q[POS_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign fright_tgt = ~pac_pos;
`endif

  ghost_target_calc #(
    .PERSONALITY    (PERSONALITY),
    .COL_W          (COL_W),
    .ROW_W          (ROW_W),
    .SHY_RADIUS     (SHY_RADIUS),
    .SCATTER_CORNER (SCATTER_CORNER)
  ) u_calc (
    .mode       (mode_q),
    .pac_pos    (pac_pos),
    .pac_dir    (pac_dir),
    .blinky_pos (blinky_pos),
    .ghost_pos  (ghost_pos),
    .fright_tgt (fright_tgt),
    .tgt        (calc_tgt)
  );

  always_comb begin
    mode_d   = mode_q;
    saved_d  = saved_q;
    sched_d  = sched_q;
    phase_d  = phase_q;
    fright_d = fright_q;
    tgt_d    = tgt_q;
    vld_d    = vld_q;

    unique case (mode_q)
      MODE_SCATTER, MODE_CHASE: begin
        // The schedule timer simply holds while away from scatter/chase.
        if (power_pellet) begin
          mode_d   = MODE_FRIGHT;
          saved_d  = mode_q;
          fright_d = T_FRIGHT;
        end else if (tick && (phase_q != LAST_PH)) begin
          if (sched_q == TMR_W'(1)) begin
            mode_d  = (mode_q == MODE_SCATTER) ? MODE_CHASE : MODE_SCATTER;
            sched_d = (mode_q == MODE_SCATTER) ? T_CHASE : T_SCATTER;
            phase_d = phase_q + PH_W'(1);
          end else begin
            sched_d = sched_q - TMR_W'(1);
          end
        end
      end
      MODE_FRIGHT: begin
        if (eaten) begin
          mode_d = MODE_EATEN;
        end else if (power_pellet) begin
          fright_d = T_FRIGHT;
        end else if (tick) begin
          if (fright_q == TMR_W'(1)) begin
            mode_d   = saved_q;
            fright_d = '0;
          end else begin
            fright_d = fright_q - TMR_W'(1);
          end
        end
      end
      MODE_EATEN: begin
        if (at_home) mode_d = saved_q;
      end
    endcase

    // Target reflects the mode in force at the tick; an unaccepted target is overwritten.
    if (tick) begin
      tgt_d = calc_tgt;
      vld_d = 1'b1;
    end else if (target_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_SCATTER;
      saved_q  <= MODE_SCATTER;
      sched_q  <= T_SCATTER;
      phase_q  <= '0;
      fright_q <= '0;
      tgt_q    <= SCATTER_CORNER;
      vld_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      saved_q  <= saved_d;
      sched_q  <= sched_d;
      phase_q  <= phase_d;
      fright_q <= fright_d;
      tgt_q    <= tgt_d;
      vld_q    <= vld_d;
    end
  end

  assign mode         = mode_q;
  assign target_pos   = tgt_q;
  assign target_valid = vld_q;

endmodule
